uart_rx_marco: RTL and testbench

- UART receiver plus fixed-keyword detector; sits directly upstream of the team's "POLO" transmitter.
- Deserialises 8N1 frames from the rx pin using a 16x oversampling tick.
- Presents each received byte, and raises a one-cycle `marco_detected` pulse when the ASCII sequence "MARCO" arrives.
- `marco_detected` connects straight to the transmitter's `send` input.

---
 rtl/uart_rx_marco.sv | 132 +++++++++++++
 tb/tb_uart_rx_marco.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_marco.sv
// 8N1 UART receiver (OSR-times oversampled, 2-flop synchronised rx) with a "MARCO" keyword detector.
// data_valid/frame_err pulse on the stop-sample edge; marco_detected follows the final 'O' by one clk.
module uart_rx_marco #(
   parameter int OSR = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       baud_tick16,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       marco_detected,
   output logic       busy
);
   localparam int CW = $clog2(OSR);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t          state, state_nxt;
   logic            rx_meta, rx_s;
   logic [CW-1:0]   tick_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic [2:0]      match_idx;
   logic            mid_start, full_bit;
   logic            sample_bit, stop_ok, stop_bad;

   function automatic logic [7:0] keyword(input logic [2:0] idx);
      case (idx)
         3'd0:    keyword = 8'h4D;
         3'd1:    keyword = 8'h41;
         3'd2:    keyword = 8'h52;
         3'd3:    keyword = 8'h43;
         default: keyword = 8'h4F;
      endcase
   endfunction

   assign mid_start = baud_tick16 && (tick_cnt == CW'(OSR/2 - 1));
   assign full_bit  = baud_tick16 && (tick_cnt == CW'(OSR - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!rx_s) state_nxt = S_START;
         S_START: if (mid_start) state_nxt = rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (full_bit && bit_idx == 3'd7) state_nxt = S_STOP;
         S_STOP:  if (full_bit) state_nxt = rx_s ? S_IDLE : S_BREAK;
         S_BREAK: if (rx_s) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != S_IDLE);
      sample_bit = (state == S_DATA) && full_bit;
      stop_ok    = (state == S_STOP) && full_bit && rx_s;
      stop_bad   = (state == S_STOP) && full_bit && !rx_s;
   end

   // Counter is held at zero in IDLE, so entering START starts a fresh count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         bit_idx  <= 3'd0;
         shift    <= 8'h00;
      end else begin
         if (state == S_IDLE || (state == S_START && mid_start))
            tick_cnt <= '0;
         else if (baud_tick16)
            tick_cnt <= (tick_cnt == CW'(OSR - 1)) ? '0 : tick_cnt + CW'(1);

         if (state != S_DATA)
            bit_idx <= 3'd0;
         else if (full_bit)
            bit_idx <= bit_idx + 3'd1;

         if (sample_bit)
            shift <= {rx_s, shift[7:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data       <= 8'h00;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= stop_ok;
         frame_err  <= stop_bad;
         if (stop_ok)
            data <= shift;
      end
   end

   // A mismatching 'M' restarts at index 1: the keyword only self-overlaps on its first letter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_idx      <= 3'd0;
         marco_detected <= 1'b0;
      end else begin
         marco_detected <= 1'b0;
         if (frame_err) begin
            match_idx <= 3'd0;
         end else if (data_valid) begin
            if (match_idx == 3'd4 && data == keyword(3'd4)) begin
               marco_detected <= 1'b1;
               match_idx      <= 3'd0;
            end else if (match_idx < 3'd4 && data == keyword(match_idx)) begin
               match_idx <= match_idx + 3'd1;
            end else begin
               match_idx <= (data == 8'h4D) ? 3'd1 : 3'd0;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_marco.sv
// Directed bench for uart_rx_marco: tick every 8 clks (OSR=16 -> 128 clks per bit).
module tb_uart_rx_marco;
   localparam int BIT = 128;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       baud_tick16 = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       data_valid, frame_err, marco_detected, busy;

   int tests = 0;
   int fails = 0;

   uart_rx_marco #(.OSR(16)) dut (
      .clk(clk), .rst_n(rst_n), .baud_tick16(baud_tick16), .rx(rx),
      .data(data), .data_valid(data_valid), .frame_err(frame_err),
      .marco_detected(marco_detected), .busy(busy)
   );

   always #5 clk = ~clk;

   int tick_div = 0;
   always @(negedge clk) begin
      tick_div    = (tick_div == 7) ? 0 : tick_div + 1;
      baud_tick16 = (tick_div == 0);
   end

   // Pulse monitor, sampled on the falling edge.
   int         cyc = 0, dv_cnt = 0, fe_cnt = 0, md_cnt = 0;
   int         last_dv_cyc = 0, md_delay = -1;
   logic [7:0] dv_data = 8'h00;
   logic       busy_at_dv = 1'b1;
   always @(negedge clk) begin
      cyc++;
      if (data_valid) begin
         dv_cnt++;
         last_dv_cyc = cyc;
         dv_data     = data;
         busy_at_dv  = busy;
      end
      if (frame_err) fe_cnt++;
      if (marco_detected) begin
         md_cnt++;
         md_delay = cyc - last_dv_cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0; idle(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = b[i]; idle(BIT);
      end
      rx = stop_bit; idle(BIT);
      rx = 1'b1;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   int dv0, fe0, md0;
   task automatic snap();
      dv0 = dv_cnt; fe0 = fe_cnt; md0 = md_cnt;
   endtask

   initial begin
      idle(3);
      rst_n = 1'b1;
      idle(1000);
      check("reset_data", 32'(data), 32'h00);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_dv", 32'(dv_cnt), 32'd0);
      check("reset_fe", 32'(fe_cnt), 32'd0);
      check("reset_md", 32'(md_cnt), 32'd0);

      snap();
      send_byte(8'h55, 1'b1); idle(BIT);
      check("single_dv", 32'(dv_cnt - dv0), 32'd1);
      check("single_data", 32'(dv_data), 32'h55);
      check("single_fe", 32'(fe_cnt - fe0), 32'd0);
      check("single_busy_at_dv", 32'(busy_at_dv), 32'd0);

      snap();
      send_str("xMARCO"); idle(BIT);
      check("kw_dv", 32'(dv_cnt - dv0), 32'd6);
      check("kw_md", 32'(md_cnt - md0), 32'd1);
      check("kw_md_delay", 32'(md_delay), 32'd1);
      check("kw_data", 32'(data), 32'h4F);

      snap(); send_str("MAMARCO"); idle(BIT);
      check("restart_md", 32'(md_cnt - md0), 32'd1);
      snap(); send_str("MARCX"); send_str("O"); idle(BIT);
      check("partial_md", 32'(md_cnt - md0), 32'd0);
      snap(); send_str("marco"); idle(BIT);
      check("lower_md", 32'(md_cnt - md0), 32'd0);
      check("lower_data", 32'(data), 32'h6F);

      snap();
      rx = 1'b0; idle(24); rx = 1'b1; idle(3 * BIT);
      check("glitch_dv", 32'(dv_cnt - dv0), 32'd0);
      check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
      check("glitch_busy", 32'(busy), 32'd0);

      snap();
      send_byte(8'h4F, 1'b0); idle(BIT);
      check("ferr_fe", 32'(fe_cnt - fe0), 32'd1);
      check("ferr_dv", 32'(dv_cnt - dv0), 32'd0);
      check("ferr_data", 32'(data), 32'h6F);

      snap();
      rx = 1'b0; idle(40 * BIT);
      check("break_fe", 32'(fe_cnt - fe0), 32'd1);
      check("break_busy", 32'(busy), 32'd1);
      rx = 1'b1; idle(BIT);
      check("break_idle", 32'(busy), 32'd0);
      send_byte(8'h41, 1'b1); idle(BIT);
      check("break_resume_dv", 32'(dv_cnt - dv0), 32'd1);
      check("break_resume_data", 32'(data), 32'h41);

      snap();
      send_str("MARC");
      rx = 1'b0; idle(BIT);
      for (int i = 0; i < 4; i++) begin
         rx = 1'(8'h4F >> i); idle(BIT);
      end
      rst_n = 1'b0; idle(2);
      check("rst_mid_data", 32'(data), 32'h00);
      check("rst_mid_busy", 32'(busy), 32'd0);
      rx = 1'b1; idle(2); rst_n = 1'b1; idle(2 * BIT);
      check("rst_mid_no_md", 32'(md_cnt - md0), 32'd0);
      send_str("MARCO"); idle(BIT);
      check("rst_mid_md", 32'(md_cnt - md0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
